iob_regfile_sub: RTL

IOb-native subordinate that terminates the valid/ready request and rvalid/rready response handshake that the team's IOb managers and testbenches drive. It holds a small bank of byte-writable 32-bit registers plus a read-only version word, and returns read data after a configurable latency. The returned data is held stable until the manager accepts it. It is the generic CSR back-end for peripherals and the reference subordinate for manager-side verification.

---
 rtl/iob_regfile_sub_pkg.sv | 21 ++
 rtl/iob_regfile_sub_strb.sv | 41 ++++
 rtl/iob_regfile_sub.sv | 132 +++++++++++++
 3 files changed

// File: rtl/iob_regfile_sub_pkg.sv
// Shared types and helpers for the IOb register-file subordinate.
// Holds the FSM state encoding, counter width and the byte-strobe merge.
package iob_regfile_sub_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StRdResp = 2'd2
    } state_e;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/iob_regfile_sub_strb.sv
// One byte-writable register with clock enable and a registered write pulse.
module iob_strb_reg
    import iob_regfile_sub_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   d_i,
    output logic [DATA_W-1:0]   q_o,
    output logic                wr_pulse_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              pulse_q, pulse_d;

    always_comb begin
        data_d = data_q;
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            data_d[b*8 +: 8] = byte_merge(data_q[b*8 +: 8], d_i[b*8 +: 8], be_i[b]);
        end
        // Pulse on any strobed write, even when the data does not change.
        pulse_d = |be_i;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q  <= '0;
            pulse_q <= 1'b0;
        end else if (cke_i) begin
            data_q  <= data_d;
            pulse_q <= pulse_d;
        end
    end

    assign q_o        = data_q;
    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/iob_regfile_sub.sv
// IOb subordinate with N_REGS byte-writable registers, a read-only version word
// and a fixed read latency; read data is captured at acceptance and held until rready.
module iob_regfile_sub
    import iob_regfile_sub_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned N_REGS  = 4,
    parameter int unsigned RD_LAT  = 2,
    parameter logic [15:0] VERSION = 16'h0081
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     iob_valid_i,
    input  logic [ADDR_W-1:0]        iob_addr_i,
    input  logic [DATA_W-1:0]        iob_wdata_i,
    input  logic [DATA_W/8-1:0]      iob_wstrb_i,
    output logic                     iob_ready_o,
    output logic                     iob_rvalid_o,
    output logic [DATA_W-1:0]        iob_rdata_o,
    input  logic                     iob_rready_i,
    output logic [N_REGS*DATA_W-1:0] regs_o,
    output logic [N_REGS-1:0]        wr_pulse_o
);

    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned StrbW = DATA_W / 8;
    localparam logic [CntW-1:0] CntLoad = (RD_LAT == 0) ? '0 : CntW'(RD_LAT - 1);
    localparam logic [DATA_W-1:0] VersionWord = DATA_W'(VERSION);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [IdxW-1:0]    idx;
    logic [DATA_W-1:0]  rd_word;
    logic               wr_acc;
    logic [StrbW-1:0]   be [N_REGS];
    logic [DATA_W-1:0]  reg_val [N_REGS];
    logic               unused_addr;

    assign idx         = iob_addr_i[ADDR_W-1:2];
    assign unused_addr = ^iob_addr_i[1:0];

    // Unmapped indices read as zero; the version word sits right after the registers.
    always_comb begin
        rd_word = '0;
        if (idx == IdxW'(N_REGS)) begin
            rd_word = VersionWord;
        end
        for (int unsigned k = 0; k < N_REGS; k++) begin
            if (idx == IdxW'(k)) begin
                rd_word = reg_val[k];
            end
        end
    end

    assign wr_acc = (state_q == StIdle) && iob_valid_i && (|iob_wstrb_i);

    for (genvar k = 0; k < N_REGS; k++) begin : g_reg
        assign be[k] = (wr_acc && (idx == IdxW'(k))) ? iob_wstrb_i : '0;

        iob_strb_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk_i      (clk_i),
            .arst_i     (arst_i),
            .cke_i      (cke_i),
            .be_i       (be[k]),
            .d_i        (iob_wdata_i),
            .q_o        (reg_val[k]),
            .wr_pulse_o (wr_pulse_o[k])
        );

        assign regs_o[k*DATA_W +: DATA_W] = reg_val[k];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (iob_valid_i && (iob_wstrb_i == '0)) begin
                    rdata_d = rd_word;
                    if (RD_LAT == 0) begin
                        state_d = StRdResp;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == '0) begin
                    state_d = StRdResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRdResp: begin
                if (iob_rready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign iob_ready_o  = (state_q == StIdle);
    assign iob_rvalid_o = (state_q == StRdResp);
    assign iob_rdata_o  = rdata_q;

    a_ready_rvalid_excl: assert property (@(posedge clk_i) disable iff (arst_i)
        !(iob_ready_o && iob_rvalid_o));
    a_rdata_held: assert property (@(posedge clk_i) disable iff (arst_i)
        (iob_rvalid_o && !iob_rready_i) |=> $stable(iob_rdata_o));

endmodule
